// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - external interrupt entry: drain, state push, vector fetch, PC redirect
module interrupt_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int ADDR_W       = 20,
  parameter int VECTOR_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              interrupt,
  input  logic [31:0]       resume_pc,
  input  logic [2:0]        flags,
  input  logic              rti_done,
  output logic              stall,
  output logic              flush,
  output logic              push_valid,
  output logic [15:0]       push_data,
  input  logic              push_ready,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic              pc_load,
  output logic [31:0]       pc_load_value,
  output logic              in_isr
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_HI,
    S_PUSH_LO,
    S_PUSH_FLG,
    S_VEC_HI,
    S_VEC_LO,
    S_JUMP
  } state_t;

  state_t             state_q, state_d;
  logic               int_q, int_d;
  logic               pending_q, pending_d;
  logic               in_isr_q, in_isr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        saved_pc_q, saved_pc_d;
  logic [2:0]         saved_flg_q, saved_flg_d;
  logic [31:0]        vec_q, vec_d;
  logic               int_edge;

  // Next-state, bookkeeping registers and all outputs decoded from the current state.
  always_comb begin
    state_d       = state_q;
    int_d         = interrupt;
    pending_d     = pending_q;
    in_isr_d      = in_isr_q;
    cnt_d         = cnt_q;
    saved_pc_d    = saved_pc_q;
    saved_flg_d   = saved_flg_q;
    vec_d         = vec_q;
    stall         = 1'b0;
    flush         = 1'b0;
    push_valid    = 1'b0;
    push_data     = 16'h0000;
    mem_rd_req    = 1'b0;
    mem_rd_addr   = '0;
    pc_load       = 1'b0;
    pc_load_value = 32'h0000_0000;

    int_edge = interrupt & ~int_q & start;

    // Return from the handler re-opens the door for the next service.
    if (rti_done) begin
      in_isr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q && !in_isr_q && start) begin
          state_d     = S_DRAIN;
          pending_d   = 1'b0;
          saved_pc_d  = resume_pc;
          saved_flg_d = flags;
          cnt_d       = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_PUSH_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PUSH_HI: begin
        stall      = 1'b1;
        push_valid = 1'b1;
        push_data  = saved_pc_q[31:16];
        if (push_ready) state_d = S_PUSH_LO;
      end
      S_PUSH_LO: begin
        stall      = 1'b1;
        push_valid = 1'b1;
        push_data  = saved_pc_q[15:0];
        if (push_ready) state_d = S_PUSH_FLG;
      end
      S_PUSH_FLG: begin
        stall      = 1'b1;
        push_valid = 1'b1;
        push_data  = {13'b0, saved_flg_q};
        if (push_ready) state_d = S_VEC_HI;
      end
      S_VEC_HI: begin
        stall       = 1'b1;
        mem_rd_req  = 1'b1;
        mem_rd_addr = ADDR_W'(VECTOR_ADDR);
        if (mem_rd_valid) begin
          vec_d[31:16] = mem_rd_data;
          state_d      = S_VEC_LO;
        end
      end
      S_VEC_LO: begin
        stall       = 1'b1;
        mem_rd_req  = 1'b1;
        mem_rd_addr = ADDR_W'(VECTOR_ADDR + 1);
        if (mem_rd_valid) begin
          vec_d[15:0] = mem_rd_data;
          state_d     = S_JUMP;
        end
      end
      S_JUMP: begin
        stall         = 1'b1;
        flush         = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = vec_q;
        in_isr_d      = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new edge wins over the clear on DRAIN entry so it is never lost.
    if (int_edge) begin
      pending_d = 1'b1;
    end
  end

  assign in_isr = in_isr_q;

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      int_q       <= 1'b0;
      pending_q   <= 1'b0;
      in_isr_q    <= 1'b0;
      cnt_q       <= '0;
      saved_pc_q  <= 32'h0000_0000;
      saved_flg_q <= 3'b000;
      vec_q       <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      pending_q   <= pending_d;
      in_isr_q    <= in_isr_d;
      cnt_q       <= cnt_d;
      saved_pc_q  <= saved_pc_d;
      saved_flg_q <= saved_flg_d;
      vec_q       <= vec_d;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst, start, interrupt, rti_done, push_ready;
  logic [31:0] resume_pc;
  logic [2:0]  flags;
  logic        stall, flush, push_valid, mem_rd_req, mem_rd_valid, pc_load, in_isr;
  logic [15:0] push_data, mem_rd_data;
  logic [19:0] mem_rd_addr;
  logic [31:0] pc_load_value;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lo_wait = 0;
  int lo_delay = 0;
  int flush_cnt = 0;
  int stall_cyc = 0;

  logic [15:0] push_log[$];
  int          load_cyc[$];
  logic [31:0] load_val[$];

  typedef struct {
    int          kind;
    logic [15:0] word;
  } step_t;

  step_t       m_steps[$];
  logic        m_ok = 1'b0;
  logic        m_pending, m_in_isr, m_int_prev;
  logic [31:0] m_vec;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .interrupt(interrupt),
    .resume_pc(resume_pc), .flags(flags), .rti_done(rti_done),
    .stall(stall), .flush(flush), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .in_isr(in_isr)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
    lo_wait <= (mem_rd_req && mem_rd_addr == 20'd1) ? lo_wait + 1 : 0;
  end

  // Vector words: high 0x0000 at address 0, low 0x0200 at address 1.
  assign mem_rd_data  = (mem_rd_addr == 20'd0) ? 16'h0000 :
                        (mem_rd_addr == 20'd1) ? 16'h0200 : 16'hdead;
  assign mem_rd_valid = mem_rd_req && ((mem_rd_addr != 20'd1) || (lo_wait >= lo_delay));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Model: a service is a script of steps (drain cycles, three pushes, two reads, jump)
  // consumed one per cycle as each step's completion condition is met.
  initial begin
    logic [73:0] exp_v, act_v;
    logic        edge_now, begin_svc, done;
    step_t       hd, st;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        exp_v = '0;
        if (m_steps.size() != 0) begin
          hd = m_steps[0];
          exp_v[73] = 1'b1;
          case (hd.kind)
            1: begin exp_v[71] = 1'b1; exp_v[70:55] = hd.word; end
            2: begin exp_v[54] = 1'b1; exp_v[53:34] = 20'd0; end
            3: begin exp_v[54] = 1'b1; exp_v[53:34] = 20'd1; end
            4: begin exp_v[72] = 1'b1; exp_v[33] = 1'b1; exp_v[32:1] = m_vec; end
            default: ;
          endcase
        end
        exp_v[0] = m_in_isr;
        act_v = {stall, flush, push_valid, push_data, mem_rd_req, mem_rd_addr,
                 pc_load, pc_load_value, in_isr};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL cycle_model cyc=%0d actual=0x%h required=0x%h", cyc, act_v, exp_v);
        end
        if (push_valid && push_ready) push_log.push_back(push_data);
        if (pc_load) begin
          load_cyc.push_back(cyc);
          load_val.push_back(pc_load_value);
        end
        if (flush) flush_cnt++;
        if (stall) stall_cyc++;
      end
      if (rst) begin
        m_ok       = 1'b1;
        m_pending  = 1'b0;
        m_in_isr   = 1'b0;
        m_int_prev = 1'b0;
        m_vec      = 32'h0;
        m_steps.delete();
      end else if (m_ok) begin
        edge_now  = interrupt && !m_int_prev && start;
        begin_svc = (m_steps.size() == 0) && m_pending && !m_in_isr && start;
        if (m_steps.size() != 0) begin
          hd   = m_steps[0];
          done = 1'b0;
          case (hd.kind)
            0: done = 1'b1;
            1: done = push_ready;
            2: if (mem_rd_valid) begin m_vec[31:16] = mem_rd_data; done = 1'b1; end
            3: if (mem_rd_valid) begin m_vec[15:0] = mem_rd_data; done = 1'b1; end
            default: done = 1'b1;
          endcase
          if (hd.kind == 4) m_in_isr = 1'b1;
          else if (rti_done) m_in_isr = 1'b0;
          if (done) void'(m_steps.pop_front());
        end else if (rti_done) begin
          m_in_isr = 1'b0;
        end
        if (begin_svc) begin
          for (int i = 0; i < DRAIN; i++) begin st.kind = 0; st.word = 16'h0; m_steps.push_back(st); end
          st.kind = 1; st.word = resume_pc[31:16];   m_steps.push_back(st);
          st.word = resume_pc[15:0];                  m_steps.push_back(st);
          st.word = {13'b0, flags};                   m_steps.push_back(st);
          st.kind = 2; st.word = 16'h0;               m_steps.push_back(st);
          st.kind = 3;                                m_steps.push_back(st);
          st.kind = 4;                                m_steps.push_back(st);
          m_pending = 1'b0;
        end
        if (edge_now) m_pending = 1'b1;
        m_int_prev = interrupt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_int();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
  endtask

  task automatic pulse_rti();
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
  endtask

  task automatic wait_load(input int n0, input string nm);
    for (int i = 0; i < 40; i++) begin
      if (load_cyc.size() > n0) break;
      tick();
    end
    chk(nm, (load_cyc.size() > n0) ? 1 : 0, 1);
  endtask

  task automatic chk_pushes(input int p0, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input string nm);
    chk({nm, "_count"}, push_log.size() - p0, 3);
    if (push_log.size() >= p0 + 3) begin
      chk({nm, "_w0"}, push_log[p0], w0);
      chk({nm, "_w1"}, push_log[p0 + 1], w1);
      chk({nm, "_w2"}, push_log[p0 + 2], w2);
    end
  endtask

  initial begin
    int e, n0, p0, f0, s0;
    rst = 1'b1; start = 1'b1; interrupt = 1'b0; rti_done = 1'b0; push_ready = 1'b1;
    resume_pc = 32'h0; flags = 3'b0;
    repeat (3) tick();
    chk("reset_outputs", {stall, flush, push_valid, mem_rd_req, pc_load, in_isr}, 6'b0);
    rst = 1'b0;
    tick();

    // Basic entry
    resume_pc = 32'h0000_0123; flags = 3'b101;
    n0 = load_cyc.size(); p0 = push_log.size(); f0 = flush_cnt; e = cyc;
    pulse_int();
    wait_load(n0, "basic_load_seen");
    if (load_cyc.size() > n0) begin
      chk("basic_latency", load_cyc[n0] - e, 10);
      chk("basic_vector", load_val[n0], 32'h0000_0200);
    end
    chk_pushes(p0, 16'h0000, 16'h0123, 16'h0005, "basic_push");
    chk("basic_flush_once", flush_cnt - f0, 1);
    chk("basic_in_isr", in_isr, 1'b1);
    pulse_rti();
    tick();

    // Backpressure: push_ready low 4 cycles in PUSH_HI, low read word delayed 3 cycles
    push_ready = 1'b0; lo_delay = 3;
    resume_pc = 32'h0001_4567; flags = 3'b010;
    n0 = load_cyc.size(); p0 = push_log.size(); e = cyc;
    pulse_int();
    for (int i = 0; i < 20; i++) begin
      if (push_valid) break;
      tick();
    end
    chk("bp_push_valid_seen", push_valid, 1'b1);
    repeat (3) tick();
    chk("bp_hold_data", {push_valid, push_data}, {1'b1, 16'h0001});
    tick();
    push_ready = 1'b1;
    wait_load(n0, "bp_load_seen");
    if (load_cyc.size() > n0) begin
      chk("bp_latency", load_cyc[n0] - e, 17);
      chk("bp_vector", load_val[n0], 32'h0000_0200);
    end
    chk_pushes(p0, 16'h0001, 16'h4567, 16'h0002, "bp_push");
    lo_delay = 0;
    pulse_rti();
    tick();

    // Nesting: edge during handler is held until RTI
    resume_pc = 32'h1111_2222; flags = 3'b000;
    n0 = load_cyc.size();
    pulse_int();
    wait_load(n0, "nest_first_load");
    tick();
    resume_pc = 32'hABCD_0010; flags = 3'b011;
    p0 = push_log.size(); s0 = stall_cyc;
    pulse_int();
    repeat (15) tick();
    chk("nest_no_push", push_log.size() - p0, 0);
    chk("nest_no_stall", stall_cyc - s0, 0);
    n0 = load_cyc.size();
    pulse_rti();
    chk("nest_rti_clears", {in_isr, stall}, 2'b00);
    tick();
    chk("nest_drain_starts", stall, 1'b1);
    wait_load(n0, "nest_second_load");
    chk_pushes(p0, 16'hABCD, 16'h0010, 16'h0003, "nest_push");
    tick();

    // Coalescing: three extra edges during a service give exactly one more service
    pulse_rti();
    tick();
    n0 = load_cyc.size();
    pulse_int();
    tick();
    pulse_int(); tick();
    pulse_int(); tick();
    pulse_int();
    wait_load(n0, "coal_first_load");
    repeat (10) tick();
    chk("coal_held", load_cyc.size() - n0, 1);
    pulse_rti();
    wait_load(n0 + 1, "coal_second_load");
    repeat (20) tick();
    chk("coal_total", load_cyc.size() - n0, 2);
    pulse_rti();
    tick();

    // Gating: edge while start=0 is ignored
    start = 1'b0;
    n0 = load_cyc.size(); s0 = stall_cyc;
    pulse_int();
    repeat (3) tick();
    start = 1'b1;
    repeat (15) tick();
    chk("gate_no_stall", stall_cyc - s0, 0);
    chk("gate_no_load", load_cyc.size() - n0, 0);

    // Reset in the middle of PUSH_LO
    resume_pc = 32'h5555_6666; flags = 3'b001;
    n0 = load_cyc.size(); p0 = push_log.size();
    pulse_int();
    repeat (5) tick();
    chk("rst_in_push_lo", {push_valid, push_data}, {1'b1, 16'h6666});
    push_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", {stall, push_valid, in_isr, pc_load, flush}, 5'b0);
    tick();
    rst = 1'b0; push_ready = 1'b1;
    repeat (20) tick();
    chk("rst_partial_push", push_log.size() - p0, 1);
    chk("rst_no_load", load_cyc.size() - n0, 0);

    // Simultaneous RTI and edge
    resume_pc = 32'h0000_0777; flags = 3'b100;
    n0 = load_cyc.size();
    pulse_int();
    wait_load(n0, "sim_first_load");
    resume_pc = 32'h0000_0888;
    n0 = load_cyc.size(); p0 = push_log.size();
    rti_done = 1'b1; interrupt = 1'b1;
    tick();
    rti_done = 1'b0; interrupt = 1'b0;
    chk("sim_isr_cleared", {in_isr, stall}, 2'b00);
    tick();
    chk("sim_drain_next", stall, 1'b1);
    wait_load(n0, "sim_second_load");
    chk_pushes(p0, 16'h0000, 16'h0888, 16'h0004, "sim_push");
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Controls the processor's external interrupt entry.
- Detects a rising edge on interrupt, stalls fetch, and drains the pipeline.
- Pushes the return PC (two 16-bit words) and the flags to the stack through a valid/ready push port owned by the datapath.
- Fetches the 32-bit handler address from the vector words in instruction memory, then redirects the PC with a load pulse plus a pipeline flush.

Parameters:
- DRAIN_CYCLES, 3: stall cycles before state save, equal to pipeline depth behind fetch; must be >=1.
- ADDR_W, 20: instruction-memory address width.
- VECTOR_ADDR, 0: address of the handler PC high word; the low word is at VECTOR_ADDR+1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  processor run enable; interrupt edges are ignored while 0
- interrupt  in  1  external interrupt request, level input, edge-detected internally
- resume_pc  in  32  PC of the next instruction to execute, sampled on DRAIN entry
- flags  in  3  {C,N,Z}, sampled on DRAIN entry
- rti_done  in  1  one-cycle pulse from the datapath when an RTI completes
- stall  out  1  freezes fetch/PC update
- flush  out  1  one-cycle pipeline flush
- push_valid  out  1  stack push request
- push_data  out  16  stack push word
- push_ready  in  1  datapath accepted push_data this cycle
- mem_rd_req  out  1  instruction-memory read request
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  16  read data
- pc_load  out  1  one-cycle PC overwrite strobe
- pc_load_value  out  32  new PC
- in_isr  out  1  handler active; nesting disabled

Behaviour:
- Clock and reset:
  - Single clock.
  - rst is synchronous and active-high. In the cycle after rst is sampled high, all outputs are 0, FSM=IDLE, pending=0, in_isr=0, and the edge register int_q=0.
  - rst mid-sequence aborts immediately with the same values; no partial push is completed.
- Edge detect:
  - int_q <= interrupt.
  - An edge is interrupt & ~int_q & start.
  - An edge sets pending regardless of in_isr. pending is one deep, so further edges coalesce.
  - pending clears in the cycle the FSM enters DRAIN.
- rti_done clears in_isr. If rti_done and an edge occur in the same cycle, in_isr clears and pending sets; service starts the next cycle.
- FSM states and transitions:
  - IDLE: if pending & ~in_isr & start, go to DRAIN. Latch saved_pc=resume_pc and saved_flg=flags, and load cnt=DRAIN_CYCLES-1.
  - DRAIN: stall=1. While cnt!=0, decrement. When cnt==0, go to PUSH_HI.
  - PUSH_HI: stall=1, push_valid=1, push_data=saved_pc[31:16]. Hold until push_ready, then go to PUSH_LO.
  - PUSH_LO: as PUSH_HI with push_data=saved_pc[15:0], then go to PUSH_FLG.
  - PUSH_FLG: push_data={13'b0,saved_flg}; on push_ready go to VEC_HI.
  - VEC_HI: stall=1, mem_rd_req=1, mem_rd_addr=VECTOR_ADDR. On mem_rd_valid, vec[31:16]=mem_rd_data; go to VEC_LO.
  - VEC_LO: mem_rd_addr=VECTOR_ADDR+1. On mem_rd_valid, vec[15:0]=mem_rd_data; go to JUMP.
  - JUMP: pc_load=1, pc_load_value=vec, flush=1, stall=1 for this cycle only. in_isr<=1; go to IDLE.
- Handshake rules:
  - push_data is stable while push_valid=1 and ~push_ready.
  - mem_rd_addr is stable while mem_rd_req=1.
  - mem_rd_valid is ignored outside VEC_HI/VEC_LO.
  - push_ready is ignored when push_valid=0.
- Latency with push_ready and mem_rd_valid tied high: edge cycle E sets pending at E+1; DRAIN at E+2; JUMP at E+2+DRAIN_CYCLES+5. With the default DRAIN_CYCLES=3, pc_load is high 10 cycles after the edge.
- start dropping to 0 mid-sequence does not abort; only rst aborts.
- The interrupt level held high produces a single service (edge-based).

Test Plan:
- Reset: assert rst 2 cycles mid-PUSH_LO -> next cycle stall=0, push_valid=0, in_isr=0, FSM IDLE; no further push or pc_load.
- Basic entry: DRAIN_CYCLES=3, resume_pc=0x0000_0123, flags=3'b101, vector words 0x0000/0x0200, ready/valid tied high; pulse interrupt -> pushes 0x0000, 0x0123, 0x0005 in order; pc_load=1 with pc_load_value=0x0000_0200 exactly 10 cycles after the edge; flush for 1 cycle; in_isr=1.
- Backpressure: push_ready low 4 cycles in PUSH_HI, mem_rd_valid delayed 3 cycles in VEC_LO -> push_data held at 0x0000, mem_rd_addr held at 1; final pc_load_value unchanged; total latency grows by 7.
- Nesting: second edge while in_isr=1 -> no service; after rti_done, entry starts the next cycle and pushes the new resume_pc.
- Coalescing/gating: three edges during one service -> exactly one additional service after RTI. Edge with start=0 -> no pending, stall stays 0.
- Simultaneous: rti_done and an interrupt edge in the same cycle -> in_isr=0 and pending=1 next cycle; DRAIN begins one cycle later.
